i2s_to_dac: RTL and testbench
=============================

Name: i2s_to_dac

Overview:
Serializes an 8-bit parallel audio sample into an I2S-format stream for an external stereo DAC. It generates its own bit clock (BCLK) and word select (WS) by dividing the system clock. The same sample is sent on both left and right channels. It sits between the audio datapath, which supplies parallel samples, and the DAC pins.

Parameters:
DIV, 8, number of clk cycles per BCLK half-period (BCLK = clk/(2*DIV)); legal range >= 1
DATA_W, 8, sample width
SLOT_W, 16, bit slots per channel; frame = 2*SLOT_W BCLK periods; requires SLOT_W >= DATA_W+1

Ports:
clk  input  1  system clock (50 MHz nominal)
rst  input  1  asynchronous reset, active-low (asserted when 0)
en  input  1  enable; synchronous, active-high
parallel_in  input  DATA_W  sample to transmit; two's-complement audio, MSB first
serial_out  output  1  I2S serial data (SD)
i2s_bclk  output  1  I2S bit clock
i2s_ws  output  1  I2S word select; 0 = left, 1 = right

Behaviour:
- Reset (rst=0, asynchronous): div_cnt=0, i2s_bclk=0, bit_cnt=2*SLOT_W-1, i2s_ws=1, serial_out=0, sample register=0.
- All registers update on posedge clk.
- en=0 (rst=1): synchronously return to the reset state, with all outputs as listed under reset. When en is raised again, a fresh frame starts and no partial frame is resumed.
- Divider: while en=1, div_cnt counts 0..DIV-1.
  - When div_cnt==DIV-1, div_cnt wraps to 0 and i2s_bclk toggles.
  - The first rising edge of i2s_bclk occurs DIV clk cycles after reset release or en rise.
  - The first falling edge occurs 2*DIV clk cycles after reset release or en rise.
- Falling-edge event (the clk cycle in which i2s_bclk toggles 1->0). In that cycle:
  - bit_cnt increments modulo 2*SLOT_W.
  - i2s_ws and serial_out update from the new bit_cnt.
  - The DAC samples on BCLK rising edges, so data is stable half a BCLK before capture.
- Sample latch: when bit_cnt wraps to 0, parallel_in is captured into the sample register.
  - Both channels of that frame use the captured value.
  - Changes to parallel_in mid-frame have no effect until the next frame.
- Word select:
  - i2s_ws=0 for bit_cnt 0..SLOT_W-1.
  - i2s_ws=1 for bit_cnt SLOT_W..2*SLOT_W-1.
  - WS therefore changes one BCLK before each channel's MSB (standard I2S one-bit delay).
- Serial data:
  - Left channel: for bit_cnt k in 1..DATA_W, serial_out = sample[DATA_W-k].
  - Right channel: for bit_cnt SLOT_W+k in SLOT_W+1..SLOT_W+DATA_W, serial_out = sample[DATA_W-k].
  - All other slots: serial_out=0.
- Frame length: 2*SLOT_W*2*DIV clk cycles (512 clk at defaults, about 97.7 kHz frame rate at 50 MHz).
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset: rst=0 with en=1 -> serial_out=0, i2s_bclk=0, i2s_ws=1. After release, the first BCLK rise is at 8 clk, the first fall at 16 clk, and i2s_ws=0 after that fall.
- Normal frame, parallel_in=8'b11011011: serial_out at left slots 1..8 = 1,1,0,1,1,0,1,1, and slots 9..15 = 0. Right slots 17..24 carry the same pattern. Frame period is 512 clk and repeats over a 10 ms run.
- Mid-frame change: parallel_in changes at bit_cnt 5 -> the rest of the current frame is unchanged, and the new value appears from the next frame's slot 1.
- Disable: en=0 for 10 us -> all outputs 0 and i2s_ws=1 within 1 clk. On re-enable, the first slot-0 falling edge comes 16 clk later with a freshly latched sample.
- Mid-operation reset: rst=0 for 1 us with parallel_in=8'b10011001, then release with parallel_in=8'b11111001 -> outputs are at reset values during reset, and the first frame transmits 1,1,1,1,1,0,0,1 on both channels.
- Check WS: i2s_ws toggles exactly every 16 BCLK periods, only on BCLK falling edges.

Source files
------------

// File: rtl/i2s_to_dac.sv
// i2s_to_dac: serializes one parallel audio sample into an I2S stream.
// The block divides the system clock to make BCLK and derives WS from the same counters.
// Each frame latches one sample and sends it on both the left and right channel.
// All outputs come straight from registers, so the DAC pins are glitch-free.
module i2s_to_dac #(
  parameter int DIV    = 8,
  parameter int DATA_W = 8,
  parameter int SLOT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] parallel_in,
  output logic              serial_out,
  output logic              i2s_bclk,
  output logic              i2s_ws
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] LEFT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEFT_LAST  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] RIGHT_BASE = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] RIGHT_LAST = CNT_W'(SLOT_W + DATA_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sample;

  logic              div_wrap;
  logic              fall_event;
  logic [CNT_W-1:0]  bit_next;
  logic              ws_next;
  logic              data_next;
  logic              in_data_slot;
  logic [CNT_W-1:0]  slot_pos;
  logic [IDX_W-1:0]  sample_idx;

  // Decode the divider wrap, the BCLK falling-edge cycle and the next slot's WS and data bit.
  always_comb begin
    div_wrap     = (div_cnt == DIV_LAST);
    fall_event   = div_wrap && i2s_bclk;
    bit_next     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    ws_next      = (bit_next >= RIGHT_BASE);
    in_data_slot = 1'b0;
    slot_pos     = '0;
    if ((bit_next >= LEFT_FIRST) && (bit_next <= LEFT_LAST)) begin
      in_data_slot = 1'b1;
      slot_pos     = bit_next;
    end else if ((bit_next > RIGHT_BASE) && (bit_next <= RIGHT_LAST)) begin
      in_data_slot = 1'b1;
      slot_pos     = bit_next - RIGHT_BASE;
    end
    sample_idx = IDX_W'(DATA_W) - IDX_W'(slot_pos);
    data_next  = in_data_slot ? sample[sample_idx] : 1'b0;
  end

  // Clock divider: count DIV system clocks per BCLK half-period, then toggle BCLK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Slot sequencing: on each BCLK fall, advance the slot and present the new WS and data bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= BIT_LAST;
      i2s_ws     <= 1'b1;
      serial_out <= 1'b0;
    end else if (!en) begin
      bit_cnt    <= BIT_LAST;
      i2s_ws     <= 1'b1;
      serial_out <= 1'b0;
    end else if (fall_event) begin
      bit_cnt    <= bit_next;
      i2s_ws     <= ws_next;
      serial_out <= data_next;
    end
  end

  // Sample latch: capture the input once per frame, as the slot counter wraps to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample <= '0;
    end else if (!en) begin
      sample <= '0;
    end else if (fall_event && (bit_next == '0)) begin
      sample <= parallel_in;
    end
  end

endmodule

// File: tb/tb_i2s_to_dac.sv
// tb_i2s_to_dac: directed test of the I2S serializer at default parameters.
module tb_i2s_to_dac;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] parallel_in;
  logic       serial_out;
  logic       i2s_bclk;
  logic       i2s_ws;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  i2s_to_dac #(.DIV(8), .DATA_W(8), .SLOT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .parallel_in (parallel_in),
    .serial_out  (serial_out),
    .i2s_bclk    (i2s_bclk),
    .i2s_ws      (i2s_ws)
  );

  // 50 MHz system clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_output(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  function automatic logic exp_sd(input logic [7:0] pat, input int n);
    logic [7:0] t;
    if (n >= 1 && n <= 8) begin
      t = pat << (n - 1);
      return t[7];
    end else if (n >= 17 && n <= 24) begin
      t = pat << (n - 17);
      return t[7];
    end
    return 1'b0;
  endfunction

  // Slot n of frame f starts at the BCLK fall on cycle 16 + 512*f + 16*n after start.
  task automatic check_slots(input int f, input logic [7:0] pat, input int from, input int upto);
    int s;
    for (int n = from; n < upto; n++) begin
      s = 16 + 512 * f + 16 * n;
      to_cycle(s + 8);
      check_output($sformatf("sd f%0d s%0d", f, n), serial_out, exp_sd(pat, n));
      check_output($sformatf("ws f%0d s%0d", f, n), i2s_ws, (n >= 16));
      check_output($sformatf("bclk f%0d s%0d", f, n), i2s_bclk, 1'b1);
      to_cycle(s + 15);
      check_output($sformatf("ws_hold f%0d s%0d", f, n), i2s_ws, (n >= 16));
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    parallel_in = 8'b11011011;

    // Asynchronous reset with enable held high.
    #3 rst = 1'b0;
    #30;
    check_output("rst sd", serial_out, 1'b0);
    check_output("rst bclk", i2s_bclk, 1'b0);
    check_output("rst ws", i2s_ws, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;

    // First BCLK rise at 8 clk, first fall at 16 clk.
    to_cycle(7);
    check_output("first rise pre", i2s_bclk, 1'b0);
    to_cycle(8);
    check_output("first rise", i2s_bclk, 1'b1);
    to_cycle(15);
    check_output("first fall pre bclk", i2s_bclk, 1'b1);
    check_output("first fall pre ws", i2s_ws, 1'b1);
    to_cycle(16);
    check_output("first fall bclk", i2s_bclk, 1'b0);
    check_output("first fall ws", i2s_ws, 1'b0);

    // Full frame, then a mid-frame input change that only takes effect next frame.
    check_slots(0, 8'b11011011, 0, 32);
    check_slots(1, 8'b11011011, 0, 5);
    parallel_in = 8'h5A;
    check_slots(1, 8'b11011011, 5, 32);
    check_slots(2, 8'h5A, 0, 32);
    check_slots(3, 8'h5A, 0, 2);

    // Disable while slot 2 is driving a one.
    to_cycle(16 + 512 * 3 + 16 * 2 + 8);
    check_output("pre dis sd", serial_out, 1'b1);
    en = 1'b0;
    tick();
    check_output("dis sd", serial_out, 1'b0);
    check_output("dis bclk", i2s_bclk, 1'b0);
    check_output("dis ws", i2s_ws, 1'b1);
    repeat (499) tick();
    check_output("dis hold sd", serial_out, 1'b0);
    check_output("dis hold bclk", i2s_bclk, 1'b0);
    check_output("dis hold ws", i2s_ws, 1'b1);

    // Re-enable: fresh frame with a newly latched sample.
    parallel_in = 8'h3C;
    en = 1'b1;
    cyc = 0;
    to_cycle(15);
    check_output("reen pre bclk", i2s_bclk, 1'b1);
    check_output("reen pre ws", i2s_ws, 1'b1);
    to_cycle(16);
    check_output("reen fall bclk", i2s_bclk, 1'b0);
    check_output("reen fall ws", i2s_ws, 1'b0);
    check_slots(0, 8'h3C, 0, 32);
    check_slots(1, 8'h3C, 0, 3);

    // Asynchronous reset mid-frame, away from any clock edge.
    to_cycle(16 + 512 + 16 * 3 + 8);
    check_output("pre rst sd", serial_out, 1'b1);
    parallel_in = 8'b10011001;
    #5 rst = 1'b0;
    #1;
    check_output("async rst sd", serial_out, 1'b0);
    check_output("async rst bclk", i2s_bclk, 1'b0);
    check_output("async rst ws", i2s_ws, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check_output("rst hold sd", serial_out, 1'b0);
    check_output("rst hold bclk", i2s_bclk, 1'b0);
    check_output("rst hold ws", i2s_ws, 1'b1);
    parallel_in = 8'b11111001;
    rst = 1'b1;
    cyc = 0;
    to_cycle(16);
    check_output("post rst ws", i2s_ws, 1'b0);
    check_slots(0, 8'b11111001, 0, 32);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
